// File: rtl/alu_pkg.sv
// Shared constants for the ID/EX ALU issue stage: ALUFun codes, MIPS
// opcode/funct values and the registered EX control/data word.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  // ALUFun codes understood by the EX-stage ALU
  localparam logic [5:0] ALU_ADD   = 6'b000000;
  localparam logic [5:0] ALU_SUB   = 6'b000001;
  localparam logic [5:0] ALU_AND   = 6'b011000;
  localparam logic [5:0] ALU_OR    = 6'b011110;
  localparam logic [5:0] ALU_XOR   = 6'b010110;
  localparam logic [5:0] ALU_NOR   = 6'b010001;
  localparam logic [5:0] ALU_PASSA = 6'b011010;
  localparam logic [5:0] ALU_EQ    = 6'b110011;
  localparam logic [5:0] ALU_NEQ   = 6'b110001;
  localparam logic [5:0] ALU_LT    = 6'b110101;
  localparam logic [5:0] ALU_LEZ   = 6'b111101;
  localparam logic [5:0] ALU_LTZ   = 6'b111011;
  localparam logic [5:0] ALU_GTZ   = 6'b111111;
  localparam logic [5:0] ALU_SLL   = 6'b100000;
  localparam logic [5:0] ALU_SRL   = 6'b100001;
  localparam logic [5:0] ALU_SRA   = 6'b100011;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type funct values
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Everything the EX stage receives; all-zero is a bubble (ADD, unsigned)
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [5:0]        alufun;
    logic              sign;
    logic [REG_AW-1:0] dst;
    logic              reg_write;
    logic              mem_rd;
    logic              mem_wr;
    logic              branch;
    logic [DATA_W-1:0] store_data;
    logic              illegal;
  } ex_word_t;

  localparam ex_word_t EX_BUBBLE = '0;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational MIPS decoder producing the ALU control word, operands,
// enables and destination for one instruction. Unsupported encodings
// return an all-zero word with only the illegal flag set.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output ex_word_t          word
);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rt_idx;
  logic [REG_AW-1:0] rd_idx;
  logic [DATA_W-1:0] imm_se;
  logic [DATA_W-1:0] imm_ze;
  logic [DATA_W-1:0] shamt;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rt_idx = instr[20:16];
  assign rd_idx = instr[15:11];
  assign imm_se = {{16{instr[15]}}, instr[15:0]};
  assign imm_ze = {16'h0, instr[15:0]};
  assign shamt  = {27'h0, instr[10:6]};

  logic              legal;
  logic              writes;
  logic [REG_AW-1:0] dst;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [5:0]        fun;
  logic              sgn;
  logic              mem_rd;
  logic              mem_wr;
  logic              branch;

  // Decode opcode/funct into operand selects, ALU function and enables
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it
    // unassigned; a missing default would infer a latch.
    legal  = 1'b1;
    writes = 1'b0;
    dst    = '0;
    a      = rs_data;
    b      = rt_data;
    fun    = ALU_ADD;
    sgn    = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    branch = 1'b0;

    unique case (opcode)
      OP_RTYPE: begin
        writes = 1'b1;
        dst    = rd_idx;
        case (funct)
          FN_ADD:  begin fun = ALU_ADD; sgn = 1'b1; end
          FN_ADDU: fun = ALU_ADD;
          FN_SUB:  begin fun = ALU_SUB; sgn = 1'b1; end
          FN_SUBU: fun = ALU_SUB;
          FN_AND:  fun = ALU_AND;
          FN_OR:   fun = ALU_OR;
          FN_XOR:  fun = ALU_XOR;
          FN_NOR:  fun = ALU_NOR;
          FN_SLT:  begin fun = ALU_LT; sgn = 1'b1; end
          FN_SLTU: fun = ALU_LT;
          FN_SLL:  begin a = shamt; fun = ALU_SLL; end
          FN_SRL:  begin a = shamt; fun = ALU_SRL; end
          FN_SRA:  begin a = shamt; fun = ALU_SRA; end
          FN_SLLV: fun = ALU_SLL;
          FN_SRLV: fun = ALU_SRL;
          FN_SRAV: fun = ALU_SRA;
          default: legal = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        // Only bltz (rt field = 0) is handled in this stage
        if (rt_idx == '0) begin
          b = '0; fun = ALU_LTZ; sgn = 1'b1; branch = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      OP_BEQ:   begin fun = ALU_EQ;  sgn = 1'b1; branch = 1'b1; end
      OP_BNE:   begin fun = ALU_NEQ; sgn = 1'b1; branch = 1'b1; end
      OP_BLEZ:  begin b = '0; fun = ALU_LEZ; sgn = 1'b1; branch = 1'b1; end
      OP_BGTZ:  begin b = '0; fun = ALU_GTZ; sgn = 1'b1; branch = 1'b1; end
      OP_ADDI:  begin b = imm_se; fun = ALU_ADD; sgn = 1'b1; writes = 1'b1; dst = rt_idx; end
      OP_ADDIU: begin b = imm_se; fun = ALU_ADD; writes = 1'b1; dst = rt_idx; end
      OP_SLTI:  begin b = imm_se; fun = ALU_LT; sgn = 1'b1; writes = 1'b1; dst = rt_idx; end
      OP_SLTIU: begin b = imm_se; fun = ALU_LT; writes = 1'b1; dst = rt_idx; end
      OP_ANDI:  begin b = imm_ze; fun = ALU_AND; writes = 1'b1; dst = rt_idx; end
      OP_ORI:   begin b = imm_ze; fun = ALU_OR;  writes = 1'b1; dst = rt_idx; end
      OP_XORI:  begin b = imm_ze; fun = ALU_XOR; writes = 1'b1; dst = rt_idx; end
      OP_LUI: begin
        a = {instr[15:0], 16'h0}; b = '0; fun = ALU_PASSA;
        writes = 1'b1; dst = rt_idx;
      end
      OP_LW: begin
        b = imm_se; fun = ALU_ADD; sgn = 1'b1; mem_rd = 1'b1;
        writes = 1'b1; dst = rt_idx;
      end
      OP_SW:    begin b = imm_se; fun = ALU_ADD; sgn = 1'b1; mem_wr = 1'b1; end
      default:  legal = 1'b0;
    endcase
  end

  // Assemble the EX word; $0 as destination suppresses the write only
  always_comb begin
    word = EX_BUBBLE;
    if (legal) begin
      word.valid      = 1'b1;
      word.alu_a      = a;
      word.alu_b      = b;
      word.alufun     = fun;
      word.sign       = sgn;
      word.dst        = dst;
      word.reg_write  = writes && (dst != '0);
      word.mem_rd     = mem_rd;
      word.mem_wr     = mem_wr;
      word.branch     = branch;
      word.store_data = rt_data;
    end else begin
      word.illegal    = 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX register stage around alu_issue_decode. Priority on each edge:
// reset > flush > stall > load; id_valid=0 loads a bubble.
// Optional macro ILLEGAL_TRAP_EN adds ex_illegal and turns unsupported
// instructions into valid, enable-free trap slots instead of bubbles.
module id_ex_alu_issue
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_instr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_alu_a,
  output logic [DATA_W-1:0] ex_alu_b,
  output logic [5:0]        ex_alufun,
  output logic              ex_sign,
  output logic [REG_AW-1:0] ex_dst,
  output logic              ex_reg_write,
  output logic              ex_mem_rd,
  output logic              ex_mem_wr,
  output logic              ex_branch,
`ifdef ILLEGAL_TRAP_EN
  output logic              ex_illegal,
`endif
  output logic [DATA_W-1:0] ex_store_data
);

  ex_word_t dec_word;
  ex_word_t ex_d;
  ex_word_t ex_q;

  alu_issue_decode u_decode (
    .instr   (id_instr),
    .rs_data (id_rs_data),
    .rt_data (id_rt_data),
    .word    (dec_word)
  );

  // Select next EX contents: bubble, hold, trap slot or decoded word
  always_comb begin
    ex_d = dec_word;
    if (flush) begin
      ex_d = EX_BUBBLE;
    end else if (stall) begin
      ex_d = ex_q;
    end else if (!id_valid) begin
      ex_d = EX_BUBBLE;
    end else if (dec_word.illegal) begin
      ex_d = EX_BUBBLE;
`ifdef ILLEGAL_TRAP_EN
      ex_d.valid   = 1'b1;
      ex_d.illegal = 1'b1;
`endif
    end
  end

  // EX pipeline register with synchronous reset to a bubble
  always_ff @(posedge clk) begin
    // NOTE: state is written with <= so every flop samples its pre-edge
    // value; blocking assignments here would create ordering races.
    if (reset) ex_q <= EX_BUBBLE;
    else       ex_q <= ex_d;
  end

  assign ex_valid      = ex_q.valid;
  assign ex_alu_a      = ex_q.alu_a;
  assign ex_alu_b      = ex_q.alu_b;
  assign ex_alufun     = ex_q.alufun;
  assign ex_sign       = ex_q.sign;
  assign ex_dst        = ex_q.dst;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_rd     = ex_q.mem_rd;
  assign ex_mem_wr     = ex_q.mem_wr;
  assign ex_branch     = ex_q.branch;
  assign ex_store_data = ex_q.store_data;
`ifdef ILLEGAL_TRAP_EN
  assign ex_illegal    = ex_q.illegal;
`endif

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Self-checking bench for id_ex_alu_issue: directed steps from the test
// plan followed by randomized traffic, checked against a mnemonic-level
// reference model. Honours ILLEGAL_TRAP_EN when defined.
module tb_id_ex_alu_issue;

  logic        clk = 1'b0;
  logic        reset, id_valid, stall, flush;
  logic [31:0] id_instr, id_rs_data, id_rt_data;
  logic        ex_valid, ex_sign, ex_reg_write, ex_mem_rd, ex_mem_wr, ex_branch;
  logic [31:0] ex_alu_a, ex_alu_b, ex_store_data;
  logic [5:0]  ex_alufun;
  logic [4:0]  ex_dst;
`ifdef ILLEGAL_TRAP_EN
  logic        ex_illegal;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_ex_alu_issue dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .stall(stall),
    .flush(flush), .ex_valid(ex_valid), .ex_alu_a(ex_alu_a),
    .ex_alu_b(ex_alu_b), .ex_alufun(ex_alufun), .ex_sign(ex_sign),
    .ex_dst(ex_dst), .ex_reg_write(ex_reg_write), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_branch(ex_branch),
`ifdef ILLEGAL_TRAP_EN
    .ex_illegal(ex_illegal),
`endif
    .ex_store_data(ex_store_data)
  );

  // ---------------- reference model ----------------
  typedef enum {
    M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
    M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV,
    M_ADDI, M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI,
    M_LW, M_SW, M_BEQ, M_BNE, M_BLEZ, M_BGTZ, M_BLTZ, M_BAD
  } mn_e;

  typedef struct {
    logic        valid;
    logic [31:0] a, b;
    logic [5:0]  fun;
    logic        sign;
    logic [4:0]  dst;
    logic        rw, rd, wr, br;
    logic [31:0] sd;
    logic        ill;
  } exp_t;

  exp_t exp_q;

  function automatic exp_t bubble();
    exp_t e;
    e.valid = 0; e.a = 0; e.b = 0; e.fun = 0; e.sign = 0; e.dst = 0;
    e.rw = 0; e.rd = 0; e.wr = 0; e.br = 0; e.sd = 0; e.ill = 0;
    return e;
  endfunction

  function automatic mn_e classify(logic [31:0] ins);
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h20: return M_ADD;  6'h21: return M_ADDU; 6'h22: return M_SUB;
        6'h23: return M_SUBU; 6'h24: return M_AND;  6'h25: return M_OR;
        6'h26: return M_XOR;  6'h27: return M_NOR;  6'h2A: return M_SLT;
        6'h2B: return M_SLTU; 6'h00: return M_SLL;  6'h02: return M_SRL;
        6'h03: return M_SRA;  6'h04: return M_SLLV; 6'h06: return M_SRLV;
        6'h07: return M_SRAV;
        default: return M_BAD;
      endcase
    end
    case (op)
      6'h01: return (ins[20:16] == 5'd0) ? M_BLTZ : M_BAD;
      6'h04: return M_BEQ;   6'h05: return M_BNE;   6'h06: return M_BLEZ;
      6'h07: return M_BGTZ;  6'h08: return M_ADDI;  6'h09: return M_ADDIU;
      6'h0A: return M_SLTI;  6'h0B: return M_SLTIU; 6'h0C: return M_ANDI;
      6'h0D: return M_ORI;   6'h0E: return M_XORI;  6'h0F: return M_LUI;
      6'h23: return M_LW;    6'h2B: return M_SW;
      default: return M_BAD;
    endcase
  endfunction

  // Per-mnemonic expected slot, written straight from the decode table
  function automatic exp_t ref_issue(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt);
    exp_t e = bubble();
    mn_e m = classify(ins);
    logic [31:0] se = {{16{ins[15]}}, ins[15:0]};
    logic [31:0] ze = {16'h0, ins[15:0]};
    logic [31:0] sh = {27'h0, ins[10:6]};
    logic [4:0]  rd_f = ins[15:11];
    logic [4:0]  rt_f = ins[20:16];
    int kind; // 0 R-write, 1 I-write, 2 no write
    if (m == M_BAD) begin
`ifdef ILLEGAL_TRAP_EN
      e.valid = 1; e.ill = 1;
`endif
      return e;
    end
    e.valid = 1; e.sd = rt; e.a = rs; e.b = rt; kind = 0;
    case (m)
      M_ADD:  begin e.fun = 6'b000000; e.sign = 1; end
      M_ADDU: e.fun = 6'b000000;
      M_SUB:  begin e.fun = 6'b000001; e.sign = 1; end
      M_SUBU: e.fun = 6'b000001;
      M_AND:  e.fun = 6'b011000;
      M_OR:   e.fun = 6'b011110;
      M_XOR:  e.fun = 6'b010110;
      M_NOR:  e.fun = 6'b010001;
      M_SLT:  begin e.fun = 6'b110101; e.sign = 1; end
      M_SLTU: e.fun = 6'b110101;
      M_SLL:  begin e.a = sh; e.fun = 6'b100000; end
      M_SRL:  begin e.a = sh; e.fun = 6'b100001; end
      M_SRA:  begin e.a = sh; e.fun = 6'b100011; end
      M_SLLV: e.fun = 6'b100000;
      M_SRLV: e.fun = 6'b100001;
      M_SRAV: e.fun = 6'b100011;
      M_ADDI:  begin kind = 1; e.b = se; e.fun = 6'b000000; e.sign = 1; end
      M_ADDIU: begin kind = 1; e.b = se; e.fun = 6'b000000; end
      M_SLTI:  begin kind = 1; e.b = se; e.fun = 6'b110101; e.sign = 1; end
      M_SLTIU: begin kind = 1; e.b = se; e.fun = 6'b110101; end
      M_ANDI:  begin kind = 1; e.b = ze; e.fun = 6'b011000; end
      M_ORI:   begin kind = 1; e.b = ze; e.fun = 6'b011110; end
      M_XORI:  begin kind = 1; e.b = ze; e.fun = 6'b010110; end
      M_LUI:   begin kind = 1; e.a = ins[15:0] << 16; e.b = 0; e.fun = 6'b011010; end
      M_LW:    begin kind = 1; e.b = se; e.fun = 6'b000000; e.sign = 1; e.rd = 1; end
      M_SW:    begin kind = 2; e.b = se; e.fun = 6'b000000; e.sign = 1; e.wr = 1; end
      M_BEQ:   begin kind = 2; e.fun = 6'b110011; e.sign = 1; e.br = 1; end
      M_BNE:   begin kind = 2; e.fun = 6'b110001; e.sign = 1; e.br = 1; end
      M_BLEZ:  begin kind = 2; e.b = 0; e.fun = 6'b111101; e.sign = 1; e.br = 1; end
      M_BGTZ:  begin kind = 2; e.b = 0; e.fun = 6'b111111; e.sign = 1; e.br = 1; end
      M_BLTZ:  begin kind = 2; e.b = 0; e.fun = 6'b111011; e.sign = 1; e.br = 1; end
      default: ;
    endcase
    if (kind == 0) e.dst = rd_f;
    if (kind == 1) e.dst = rt_f;
    e.rw = (kind != 2) && (e.dst != 0);
    return e;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},  32'(ex_valid),      32'(exp_q.valid));
    check({tag, ".a"},      ex_alu_a,           exp_q.a);
    check({tag, ".b"},      ex_alu_b,           exp_q.b);
    check({tag, ".alufun"}, 32'(ex_alufun),     32'(exp_q.fun));
    check({tag, ".sign"},   32'(ex_sign),       32'(exp_q.sign));
    check({tag, ".dst"},    32'(ex_dst),        32'(exp_q.dst));
    check({tag, ".rw"},     32'(ex_reg_write),  32'(exp_q.rw));
    check({tag, ".memrd"},  32'(ex_mem_rd),     32'(exp_q.rd));
    check({tag, ".memwr"},  32'(ex_mem_wr),     32'(exp_q.wr));
    check({tag, ".branch"}, 32'(ex_branch),     32'(exp_q.br));
    check({tag, ".sdata"},  ex_store_data,      exp_q.sd);
`ifdef ILLEGAL_TRAP_EN
    check({tag, ".illegal"}, 32'(ex_illegal),   32'(exp_q.ill));
`endif
  endtask

  // Apply one cycle of inputs, advance the model, compare after the edge
  task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] rs,
                      input logic [31:0] rt, input logic v, input logic st,
                      input logic fl, input logic rst);
    id_instr = ins; id_rs_data = rs; id_rt_data = rt;
    id_valid = v; stall = st; flush = fl; reset = rst;
    @(posedge clk);
    if (rst)      exp_q = bubble();
    else if (fl)  exp_q = bubble();
    else if (st)  exp_q = exp_q;
    else if (!v)  exp_q = bubble();
    else          exp_q = ref_issue(ins, rs, rt);
    #1;
    check_all(tag);
  endtask

  // Random instruction drawn from supported and unsupported encodings
  function automatic logic [31:0] rand_instr();
    logic [5:0] rfn [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    logic [5:0] iop [18] = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
                             6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h01, 6'h3F,
                             6'h02, 6'h03};
    logic [31:0] r = $urandom;
    int sel = int'($urandom_range(0, 9));
    if (sel < 4) begin
      if ($urandom_range(0, 9) == 0) return {6'h00, r[25:6], 6'h08};
      return {6'h00, r[25:6], rfn[$urandom_range(0, 15)]};
    end
    begin
      logic [5:0] op = iop[$urandom_range(0, 17)];
      if (op == 6'h01 && r[0]) r[20:16] = 5'd0;
      return {op, r[25:0]};
    end
  endfunction

  initial begin
    exp_q = bubble();
    step("reset0", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("reset1", 32'h00221820, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0, 1'b1);

    // add $3,$1,$2
    step("add", 32'h00221820, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    check("add.a_const", ex_alu_a, 32'd5);
    check("add.dst_const", 32'(ex_dst), 32'd3);

    step("addiu", 32'h2402FFFF, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("addiu.b_const", ex_alu_b, 32'hFFFF_FFFF);
    step("andi", 32'h3002FFFF, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("andi.b_const", ex_alu_b, 32'h0000_FFFF);
    step("sra", 32'h000520C3, 32'h1111_1111, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sra.fun_const", 32'(ex_alufun), 32'b100011);
    step("lui", 32'h3C011234, 32'h5, 32'h6, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lui.a_const", ex_alu_a, 32'h1234_0000);

    // beq then stall twice with changing ID contents
    step("beq", 32'h10220004, 32'd9, 32'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step("stall1", 32'h00221820, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    step("stall2", 32'h3C01ABCD, 32'd3, 32'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    check("stall.fun_const", 32'(ex_alufun), 32'b110011);
    check("stall.br_const", 32'(ex_branch), 32'd1);
    step("flush_stall", 32'h00221820, 32'd1, 32'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    check("flush.valid_const", 32'(ex_valid), 32'd0);

    // reset mid-stream, add to $0, invalid slot, illegal opcode
    step("pre_rst", 32'h00221820, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step("mid_rst", 32'h00221820, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    step("add_r0", 32'h00010020, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    check("add_r0.rw_const", 32'(ex_reg_write), 32'd0);
    step("no_valid", 32'h00221820, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step("illegal", 32'hFC000000, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    check("illegal.valid_const", 32'(ex_valid), 32'd1);
`else
    check("illegal.valid_const", 32'(ex_valid), 32'd0);
`endif
    step("lw", 32'h8C25FFF8, 32'h100, 32'h7, 1'b1, 1'b0, 1'b0, 1'b0);
    step("sw", 32'hAC25FFF8, 32'h100, 32'h7, 1'b1, 1'b0, 1'b0, 1'b0);
    step("bltz", 32'h04200003, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", rand_instr(), $urandom, $urandom,
           ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
